// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: state machine that sequences fetch, decode,
// execute, memory and writeback phases, and counts retired instructions.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      r_state;
    state_t      w_next;
    logic        w_retire;
    logic [15:0] r_instr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_ADDI:       w_next = S_ADDI_EX;
                    OP_J:          w_next = S_JUMP;
                    default:       w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_we     = zero;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_we    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            // Sticky until reset; every datapath control stays low.
            S_HALT: begin
                illegal = 1'b1;
                w_next  = S_HALT;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign state       = r_state;
    assign instr_done  = w_retire;
    assign instr_count = r_instr_count;

endmodule
